vga_timing: RTL and testbench

//  - Raster timing generator for the 1024x768@60 Hz display path (65 MHz pixel clock).
//  - Produces hcount/vcount, blanking and sync pulses consumed by the map/object drawing stages.
//  - First stage of the video chain; all outputs are registered and mutually aligned.

---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/vga_timing_if.sv | 33 +++
 rtl/vga_axis_counter.sv | 64 ++++++
 rtl/vga_timing.sv | 107 ++++++++++
 tb/tb_vga_timing.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// XGA 1024x768@60 raster constants, phase encoding and counter widths shared by the timing slice.
// Pure declarations: no logic, no latency, no flow control.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FP,
    PH_SYNC,
    PH_BP
  } phase_t;

  localparam int HC_W = 11;
  localparam int VC_W = 10;

  localparam int XGA_H_ACTIVE = 1024;
  localparam int XGA_H_FP     = 24;
  localparam int XGA_H_SYNC   = 136;
  localparam int XGA_H_BP     = 160;
  localparam int XGA_H_TOTAL  = XGA_H_ACTIVE + XGA_H_FP + XGA_H_SYNC + XGA_H_BP;

  localparam int XGA_V_ACTIVE = 768;
  localparam int XGA_V_FP     = 3;
  localparam int XGA_V_SYNC   = 6;
  localparam int XGA_V_BP     = 29;
  localparam int XGA_V_TOTAL  = XGA_V_ACTIVE + XGA_V_FP + XGA_V_SYNC + XGA_V_BP;

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle from the timing generator to the drawing stages; frame_cnt exists only with VGA_FRAME_CNT_EN.
// All members are registered at the source; no handshake, consumers sample every pixel clock.
interface vga_timing_if;
  import vga_timing_pkg::*;

  logic [HC_W-1:0] hcount_out;
  logic [VC_W-1:0] vcount_out;
  logic            hblnk_out;
  logic            vblnk_out;
  logic            hsync_out;
  logic            vsync_out;
  logic            frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0]     frame_cnt;
`endif

  modport master (
    output hcount_out, vcount_out, hblnk_out, vblnk_out,
           hsync_out, vsync_out, frame_start
`ifdef VGA_FRAME_CNT_EN
  , output frame_cnt
`endif
  );

  modport slave (
    input hcount_out, vcount_out, hblnk_out, vblnk_out,
          hsync_out, vsync_out, frame_start
`ifdef VGA_FRAME_CNT_EN
  , input frame_cnt
`endif
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus ACTIVE/FP/SYNC/BP phase FSM, blank and sync flops.
// Count, phase, blnk and sync update together on the step edge; step=0 holds everything; wrap is combinational.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   W        = 11,
  parameter int   ACTIVE   = 1024,
  parameter int   FP       = 24,
  parameter int   SYNC     = 136,
  parameter int   BP       = 160,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  output logic [W-1:0] count,
  output phase_t       phase,
  output logic         wrap,
  output logic         blnk,
  output logic         sync
);

  localparam int           TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] FP_START   = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
  localparam logic [W-1:0] BP_START   = W'(ACTIVE + FP + SYNC);

  logic [W-1:0] count_d;
  phase_t       phase_d;

  assign wrap = step && (count == LAST);

  // Phase is decoded from the next count so blank/sync land on the same edge as the count they describe.
  always_comb begin
    count_d = count;
    phase_d = phase;
    if (step) begin
      count_d = (count == LAST) ? '0 : count + W'(1);
    end
    case (phase)
      PH_ACTIVE: if (count_d == FP_START)   phase_d = PH_FP;
      PH_FP:     if (count_d == SYNC_START) phase_d = PH_SYNC;
      PH_SYNC:   if (count_d == BP_START)   phase_d = PH_BP;
      PH_BP:     if (count_d == '0)         phase_d = PH_ACTIVE;
      default:                              phase_d = PH_ACTIVE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      phase <= PH_ACTIVE;
      blnk  <= 1'b0;
      sync  <= ~SYNC_POL;
    end else begin
      count <= count_d;
      phase <= phase_d;
      blnk  <= (phase_d != PH_ACTIVE);
      sync  <= (phase_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator (default 1024x768@60, 65 MHz); all outputs registered, blank/sync aligned to counts.
// en=0 holds every output and forces frame_start low; optional frame_cnt with VGA_FRAME_CNT_EN.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = XGA_H_ACTIVE,
  parameter int   H_FP     = XGA_H_FP,
  parameter int   H_SYNC   = XGA_H_SYNC,
  parameter int   H_BP     = XGA_H_BP,
  parameter int   V_ACTIVE = XGA_V_ACTIVE,
  parameter int   V_FP     = XGA_V_FP,
  parameter int   V_SYNC   = XGA_V_SYNC,
  parameter int   V_BP     = XGA_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  vga_timing_if.master vga
);

  logic [HC_W-1:0] h_count;
  logic [VC_W-1:0] v_count;
  phase_t          h_phase;
  phase_t          v_phase;
  logic            h_wrap;
  logic            v_wrap;
  logic            v_step;
  logic            h_blnk;
  logic            v_blnk;
  logic            h_sync;
  logic            v_sync;
  logic            frame_start_d;
  logic            frame_start_q;

  assign v_step = h_wrap & en;

  vga_axis_counter #(
    .W        (HC_W),
    .ACTIVE   (H_ACTIVE),
    .FP       (H_FP),
    .SYNC     (H_SYNC),
    .BP       (H_BP),
    .SYNC_POL (SYNC_POL)
  ) u_h (
    .clk   (clk),
    .rst   (rst),
    .step  (en),
    .count (h_count),
    .phase (h_phase),
    .wrap  (h_wrap),
    .blnk  (h_blnk),
    .sync  (h_sync)
  );

  vga_axis_counter #(
    .W        (VC_W),
    .ACTIVE   (V_ACTIVE),
    .FP       (V_FP),
    .SYNC     (V_SYNC),
    .BP       (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_v (
    .clk   (clk),
    .rst   (rst),
    .step  (v_step),
    .count (v_count),
    .phase (v_phase),
    .wrap  (v_wrap),
    .blnk  (v_blnk),
    .sync  (v_sync)
  );

  // A frame ends only while both axes sit in back porch; v_wrap already carries en.
  assign frame_start_d = v_wrap && (h_phase == PH_BP) && (v_phase == PH_BP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (frame_start_d) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign vga.frame_cnt = frame_cnt_q;
`endif

  assign vga.hcount_out  = h_count;
  assign vga.vcount_out  = v_count;
  assign vga.hblnk_out   = h_blnk;
  assign vga.vblnk_out   = v_blnk;
  assign vga.hsync_out   = h_sync;
  assign vga.vsync_out   = v_sync;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: full XGA instance for line tests, reduced-raster instances for frame, reset and polarity tests.
// A position-count model checks every cycle; directed checks pin it. VGA_FRAME_CNT_EN adds frame_cnt checks.
module tb_vga_timing;
  import vga_timing_pkg::*;

  localparam int SH_A = 16, SH_F = 2, SH_S = 3, SH_B = 4;
  localparam int SV_A = 8,  SV_F = 1, SV_S = 2, SV_B = 3;
  localparam int SHT  = SH_A + SH_F + SH_S + SH_B;   // 25
  localparam int SVT  = SV_A + SV_F + SV_S + SV_B;   // 14
  localparam int SFT  = SHT * SVT;                    // 350
  localparam int FHT  = 1344;
  localparam int FVT  = 806;
  localparam int FFT  = FHT * FVT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_f, en_f, rst_s, en_s;

  vga_timing_if if_f ();
  vga_timing_if if_s ();
  vga_timing_if if_p ();

  vga_timing u_full (.clk(clk), .rst(rst_f), .en(en_f), .vga(if_f));

  vga_timing #(
    .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B), .SYNC_POL(1'b0)
  ) u_small (.clk(clk), .rst(rst_s), .en(en_s), .vga(if_s));

  vga_timing #(
    .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B), .SYNC_POL(1'b1)
  ) u_pol (.clk(clk), .rst(rst_s), .en(en_s), .vga(if_p));

  int errs = 0;
  int checks = 0;
  int nprint = 0;
  bit model_on = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      if (nprint < 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      nprint++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: the raster is just the number of enabled pixel clocks since reset, modulo the frame.
  int n_f = 0, n_s = 0;
  bit fs_f = 0, fs_s = 0;

  always @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      n_f <= 0; fs_f <= 0;
    end else if (en_f) begin
      n_f <= (n_f + 1) % FFT; fs_f <= ((n_f + 1) % FFT) == 0;
    end else begin
      fs_f <= 0;
    end
  end

  always @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      n_s <= 0; fs_s <= 0;
    end else if (en_s) begin
      n_s <= (n_s + 1) % SFT; fs_s <= ((n_s + 1) % SFT) == 0;
    end else begin
      fs_s <= 0;
    end
  end

  task automatic cmp_model(input string tag, input int n, input bit fs,
                           input int ha, input int hf, input int hs, input int ht,
                           input int va, input int vf, input int vs, input bit pol,
                           input logic [10:0] hc, input logic [9:0] vc,
                           input logic hb, input logic vb, input logic hy,
                           input logic vy, input logic fst);
    int h, v;
    h = n % ht;
    v = n / ht;
    chk({tag, "_hcount"}, 32'(hc), h);
    chk({tag, "_vcount"}, 32'(vc), v);
    chk({tag, "_hblnk"}, 32'(hb), 32'(h >= ha));
    chk({tag, "_vblnk"}, 32'(vb), 32'(v >= va));
    chk({tag, "_hsync"}, 32'(hy), 32'(((h >= ha + hf) && (h < ha + hf + hs)) ? pol : !pol));
    chk({tag, "_vsync"}, 32'(vy), 32'(((v >= va + vf) && (v < va + vf + vs)) ? pol : !pol));
    chk({tag, "_frame_start"}, 32'(fst), 32'(fs));
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      cmp_model("full", n_f, fs_f, 1024, 24, 136, FHT, 768, 3, 6, 1'b0,
                if_f.hcount_out, if_f.vcount_out, if_f.hblnk_out, if_f.vblnk_out,
                if_f.hsync_out, if_f.vsync_out, if_f.frame_start);
      cmp_model("small", n_s, fs_s, SH_A, SH_F, SH_S, SHT, SV_A, SV_F, SV_S, 1'b0,
                if_s.hcount_out, if_s.vcount_out, if_s.hblnk_out, if_s.vblnk_out,
                if_s.hsync_out, if_s.vsync_out, if_s.frame_start);
      cmp_model("pol", n_s, fs_s, SH_A, SH_F, SH_S, SHT, SV_A, SV_F, SV_S, 1'b1,
                if_p.hcount_out, if_p.vcount_out, if_p.hblnk_out, if_p.vblnk_out,
                if_p.hsync_out, if_p.vsync_out, if_p.frame_start);
    end
  end

  initial begin
    int lows, first_low, last_low, rise, bad, steps, fs_cnt, fs_at;
    int vb_min, vb_max, vs_lines, vs_first, ph_hi, ph_min, ph_max, pv_min, pv_max;
    int pat [4] = '{1, 0, 0, 1};
    int expc [4] = '{501, 501, 501, 502};
    bit vs_seen [SVT];

    rst_f = 1'b1; rst_s = 1'b1; en_f = 1'b0; en_s = 1'b0;
    repeat (2) tick();

    chk("rst_hcount", 32'(if_f.hcount_out), 0);
    chk("rst_vcount", 32'(if_f.vcount_out), 0);
    chk("rst_hblnk", 32'(if_f.hblnk_out), 0);
    chk("rst_vblnk", 32'(if_f.vblnk_out), 0);
    chk("rst_hsync", 32'(if_f.hsync_out), 1);
    chk("rst_vsync", 32'(if_f.vsync_out), 1);
    chk("rst_frame_start", 32'(if_f.frame_start), 0);
    chk("rst_pol_hsync", 32'(if_p.hsync_out), 0);
    chk("rst_pol_vsync", 32'(if_p.vsync_out), 0);

    model_on = 1;
    rst_f = 1'b0; rst_s = 1'b0;
    tick();
    chk("release_no_fs", 32'(if_f.frame_start), 0);
    chk("release_hold_hcount", 32'(if_f.hcount_out), 0);

    // One full XGA line.
    en_f = 1'b1;
    lows = 0; first_low = -1; last_low = -1; rise = -1; bad = 0;
    for (int i = 0; i < FHT; i++) begin
      tick();
      if (int'(if_f.hcount_out) != (i + 1) % FHT) bad++;
      if (if_f.hsync_out == 1'b0) begin
        lows++;
        if (first_low < 0) first_low = int'(if_f.hcount_out);
        last_low = int'(if_f.hcount_out);
      end
      if (rise < 0 && if_f.hblnk_out) rise = int'(if_f.hcount_out);
    end
    chk("hcount_seq_bad", bad, 0);
    chk("hblnk_rise_at", rise, 1024);
    chk("hsync_low_cycles", lows, 136);
    chk("hsync_first_low", first_low, 1048);
    chk("hsync_last_low", last_low, 1183);
    chk("line_wrap_hcount", 32'(if_f.hcount_out), 0);
    chk("line_wrap_vcount", 32'(if_f.vcount_out), 1);

    // Pixel-enable hold at hcount=500.
    repeat (500) tick();
    chk("en_pre_hcount", 32'(if_f.hcount_out), 500);
    for (int k = 0; k < 4; k++) begin
      en_f = pat[k][0];
      tick();
      chk("en_toggle_hcount", 32'(if_f.hcount_out), expc[k]);
      if (pat[k] == 0) chk("en_low_no_fs", 32'(if_f.frame_start), 0);
    end
    en_f = 1'b0;

    // One full reduced frame on the small and polarity instances.
    en_s = 1'b1;
    vb_min = 99; vb_max = -1; vs_first = -1; vs_lines = 0; fs_cnt = 0; fs_at = -1;
    ph_hi = 0; ph_min = 99; ph_max = -1; pv_min = 99; pv_max = -1;
    for (int v = 0; v < SVT; v++) vs_seen[v] = 0;
    for (int i = 0; i < SFT; i++) begin
      tick();
      if (if_s.vblnk_out) begin
        if (int'(if_s.vcount_out) < vb_min) vb_min = int'(if_s.vcount_out);
        if (int'(if_s.vcount_out) > vb_max) vb_max = int'(if_s.vcount_out);
      end
      if (!if_s.vsync_out && !vs_seen[if_s.vcount_out]) begin
        vs_seen[if_s.vcount_out] = 1;
        vs_lines++;
        if (vs_first < 0) vs_first = int'(if_s.vcount_out);
      end
      if (if_s.frame_start) begin
        fs_cnt++;
        fs_at = i;
        chk("fs_at_origin", {if_s.hcount_out, 11'(if_s.vcount_out)}, 0);
      end
      if (if_p.hsync_out) begin
        ph_hi++;
        if (int'(if_p.hcount_out) < ph_min) ph_min = int'(if_p.hcount_out);
        if (int'(if_p.hcount_out) > ph_max) ph_max = int'(if_p.hcount_out);
      end
      if (if_p.vsync_out) begin
        if (int'(if_p.vcount_out) < pv_min) pv_min = int'(if_p.vcount_out);
        if (int'(if_p.vcount_out) > pv_max) pv_max = int'(if_p.vcount_out);
      end
    end
    chk("vblnk_first_line", vb_min, 8);
    chk("vblnk_last_line", vb_max, 13);
    chk("vsync_lines", vs_lines, 2);
    chk("vsync_first_line", vs_first, 9);
    chk("fs_pulses_per_frame", fs_cnt, 1);
    chk("fs_cycle", fs_at, SFT - 1);
    chk("pol_hsync_high_cycles", ph_hi, 42);
    chk("pol_hsync_min_h", ph_min, 18);
    chk("pol_hsync_max_h", ph_max, 20);
    chk("pol_vsync_min_v", pv_min, 9);
    chk("pol_vsync_max_v", pv_max, 10);

    // Asynchronous reset while in hsync/vsync/blanking at (19,9).
    repeat (9 * SHT + 19) tick();
    chk("pre_rst_pos", {if_s.hcount_out, 11'(if_s.vcount_out)}, {11'd19, 11'd9});
    #2;
    rst_s = 1'b1;
    #1;
    chk("arst_hcount", 32'(if_s.hcount_out), 0);
    chk("arst_vcount", 32'(if_s.vcount_out), 0);
    chk("arst_blnk", {if_s.hblnk_out, if_s.vblnk_out}, 0);
    chk("arst_sync", {if_s.hsync_out, if_s.vsync_out}, 2'b11);
    chk("arst_pol_sync", {if_p.hsync_out, if_p.vsync_out}, 2'b00);
    repeat (3) tick();
    rst_s = 1'b0;
    chk("rst_hold_pos", {if_s.hcount_out, 11'(if_s.vcount_out)}, 0);
    tick();
    chk("resume_hcount", 32'(if_s.hcount_out), 1);
    steps = 1;
    while (!if_s.frame_start && steps < 3 * SFT) begin
      tick();
      steps++;
    end
    chk("first_frame_len", steps, SFT);

`ifdef VGA_FRAME_CNT_EN
    repeat (2 * SFT) tick();
    chk("frame_cnt_3", 32'(if_s.frame_cnt), 3);
    repeat (100) tick();
    force u_small.frame_cnt_q = 16'hFFFF;
    tick();
    release u_small.frame_cnt_q;
    steps = 0;
    while (!if_s.frame_start && steps < 2 * SFT) begin
      tick();
      steps++;
    end
    chk("frame_cnt_wrap", 32'(if_s.frame_cnt), 0);
`endif

    model_on = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
